aes_round_ctrl: RTL and testbench

Iterative round sequencer that sits directly upstream of aes_rounddata and closes the loop around it.
- Accepts a 128-bit block over a valid/ready handshake and holds the AES state register that drives aes_rounddata data_in.
- Drives round, width_sel and mode to aes_rounddata, and captures its data_out at the end of each round.
- Sequences rounds 0..Nr and presents the ciphertext on an output valid/ready handshake.

---
 rtl/aes_round_ctrl.sv | 119 +++++++++++
 tb/tb_aes_round_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: owns the state register feeding aes_rounddata,
// steps rounds 0..Nr and hands the ciphertext out over a valid/ready handshake.
module aes_round_ctrl #(
   parameter int unsigned ROUND_CYCLES = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [1:0]   mode_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic [3:0]   round,
   output logic [3:0]   width_sel,
   output logic [1:0]   mode,
   output logic [127:0] state_out,
   input  logic [127:0] rd_data_out,
   input  logic         rk_valid,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StR0, StRnd, StDone} st_e;

   localparam logic [4:0] LastSub = 5'(ROUND_CYCLES - 1);

   st_e           st_q, st_d;
   logic [4:0]    sub_q, sub_d;
   logic [3:0]    round_q, round_d;
   logic [1:0]    mode_q, mode_d;
   logic [127:0]  data_q, data_d;
   logic [3:0]    nr;

   always_comb begin
      unique case (mode_q)
         2'b00:   nr = 4'd10;
         2'b01:   nr = 4'd12;
         default: nr = 4'd14;
      endcase
   end

   always_comb begin
      st_d    = st_q;
      sub_d   = sub_q;
      round_d = round_q;
      mode_d  = mode_q;
      data_d  = data_q;
      unique case (st_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = in_block;
               mode_d  = mode_in;
               round_d = 4'd0;
               sub_d   = 5'd0;
               st_d    = StR0;
            end
         end
         StR0: begin
            if (rk_valid) begin
               data_d  = rd_data_out;
               round_d = 4'd1;
               sub_d   = 5'd0;
               st_d    = StRnd;
            end
         end
         StRnd: begin
            // The round key is only qualified at sub 0; later drops are ignored.
            if (!(sub_q == 5'd0 && !rk_valid)) begin
               if (sub_q == LastSub) begin
                  data_d = rd_data_out;
                  sub_d  = 5'd0;
                  if (round_q == nr) begin
                     st_d = StDone;
                  end else begin
                     round_d = round_q + 4'd1;
                  end
               end else begin
                  sub_d = sub_q + 5'd1;
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               st_d    = StIdle;
               round_d = 4'd0;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= StIdle;
         sub_q   <= 5'd0;
         round_q <= 4'd0;
         mode_q  <= 2'b00;
         data_q  <= 128'd0;
      end else begin
         st_q    <= st_d;
         sub_q   <= sub_d;
         round_q <= round_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = (st_q == StIdle);
   assign busy      = (st_q != StIdle);
   assign out_valid = (st_q == StDone);
   assign out_block = data_q;
   assign state_out = data_q;
   assign round     = round_q;
   assign mode      = mode_q;
   // Wraps during the drain cycles; the datapath ignores those values.
   assign width_sel = sub_q[3:0];

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl; a simple keyed permutation stands in for
// aes_rounddata so the captured result of every round is predictable.
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic [1:0]   mode_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic [3:0]   round;
   logic [3:0]   width_sel;
   logic [1:0]   mode;
   logic [127:0] state_out;
   logic [127:0] rd_data_out;
   logic         rk_valid;
   logic         busy;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [127:0] Pt1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] Pt2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] Junk = 128'hdeadbeefcafef00d0123456789abcdef;

   aes_round_ctrl #(.ROUND_CYCLES(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_block    (in_block),
      .mode_in     (mode_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_block   (out_block),
      .round       (round),
      .width_sel   (width_sel),
      .mode        (mode),
      .state_out   (state_out),
      .rd_data_out (rd_data_out),
      .rk_valid    (rk_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rd_fn(input logic [127:0] s, input logic [3:0] r);
      return {s[119:0], s[127:120]} ^ {96'h0, 28'h5a5a5a5, r};
   endfunction

   assign rd_data_out = rd_fn(state_out, round);

   function automatic logic [127:0] exp_ct(input logic [127:0] pt, input int nr);
      logic [127:0] s = pt;
      for (int r = 0; r <= nr; r++) s = rd_fn(s, 4'(r));
      return s;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
      chk({tag, "_busy"}, 128'(busy), 128'd0);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
      chk({tag, "_round"}, 128'(round), 128'd0);
      chk({tag, "_width_sel"}, 128'(width_sel), 128'd0);
      chk({tag, "_mode"}, 128'(mode), 128'd0);
      chk({tag, "_state_out"}, state_out, 128'd0);
   endtask

   // Runs one block. stall: 5-cycle rk_valid gaps at R0 and at round 3 sub 0,
   // plus a harmless drop at round 2 sub 7. inj: round in which a foreign block
   // is offered. hold: leave the result pending in DONE.
   task automatic run_block(input string tag, input logic [127:0] pt, input logic [1:0] md,
                            input int nr, input bit stall, input int inj, input bit hold);
      int lat = 0;
      int steps = 0;
      int bad_step = 0;
      int r0_left = stall ? 5 : 0;
      int rs_left = stall ? 5 : 0;
      bit rs_started = 1'b0;
      bit injected = 1'b0;
      bit stalled = 1'b0;
      bit done = 1'b0;
      logic [3:0] prev_round = 4'd0;
      int exp_lat = 1 + nr * 20 + (stall ? 10 : 0);

      in_block = pt;
      mode_in  = md;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_block = ~pt;
      mode_in  = ~md;
      chk({tag, "_accept_busy"}, 128'(busy), 128'd1);
      chk({tag, "_mode"}, 128'(mode), 128'(md));

      while (!done && lat < 600) begin
         rk_valid = 1'b1;
         stalled  = 1'b0;
         if (round == 4'd3 && width_sel != 4'd0) rs_started = 1'b1;
         if (busy && round == 4'd0 && r0_left > 0) begin
            rk_valid = 1'b0;
            stalled  = 1'b1;
            r0_left--;
         end else if (round == 4'd3 && width_sel == 4'd0 && !rs_started && rs_left > 0) begin
            rk_valid = 1'b0;
            stalled  = 1'b1;
            rs_left--;
         end else if (stall && round == 4'd2 && width_sel == 4'd7) begin
            rk_valid = 1'b0;
         end
         if (inj != 0 && !injected && round == 4'(inj) && width_sel == 4'd5) begin
            in_valid = 1'b1;
            in_block = Junk;
            mode_in  = 2'b01;
            injected = 1'b1;
         end
         @(posedge clk); #1;
         lat++;
         if (in_valid) begin
            in_valid = 1'b0;
            chk({tag, "_inj_ignored_busy"}, 128'(busy), 128'd1);
            chk({tag, "_inj_mode_kept"}, 128'(mode), 128'(md));
         end
         if (stalled) chk({tag, "_stall_wsel"}, 128'(width_sel), 128'd0);
         if (round != prev_round) begin
            steps++;
            if (round != prev_round + 4'd1) bad_step++;
            prev_round = round;
         end
         done = out_valid;
      end
      rk_valid = 1'b1;

      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, "_out_block"}, out_block, exp_ct(pt, nr));
      chk({tag, "_round_steps"}, 128'(steps), 128'(nr));
      chk({tag, "_bad_steps"}, 128'(bad_step), 128'd0);
      chk({tag, "_final_round"}, 128'(round), 128'(nr));

      if (!hold) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk({tag, "_handoff_out_valid"}, 128'(out_valid), 128'd0);
         chk({tag, "_handoff_in_ready"}, 128'(in_ready), 128'd1);
         chk({tag, "_handoff_round"}, 128'(round), 128'd0);
      end
   endtask

   initial begin
      int guard;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_block  = '0;
      mode_in   = 2'b00;
      out_ready = 1'b0;
      rk_valid  = 1'b1;
      #1;
      chk_reset_vals("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_block("aes128", Pt1, 2'b00, 10, 1'b0, 0, 1'b0);
      run_block("aes192", Pt1, 2'b01, 12, 1'b0, 0, 1'b0);
      run_block("aes256", Pt1, 2'b10, 14, 1'b0, 0, 1'b0);
      run_block("mode11", Pt1, 2'b11, 14, 1'b0, 0, 1'b0);
      run_block("stall", Pt1, 2'b00, 10, 1'b1, 0, 1'b0);
      run_block("inject", Pt2, 2'b00, 10, 1'b0, 4, 1'b0);

      // Back-pressure in DONE with a second block waiting.
      run_block("bp", Pt1, 2'b10, 14, 1'b0, 0, 1'b1);
      in_valid = 1'b1;
      in_block = Pt2;
      mode_in  = 2'b00;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", 128'(out_valid), 128'd1);
         chk("bp_out_block", out_block, exp_ct(Pt1, 14));
         chk("bp_in_ready", 128'(in_ready), 128'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_handoff_out_valid", 128'(out_valid), 128'd0);
      chk("bp_handoff_in_ready", 128'(in_ready), 128'd1);
      chk("bp_handoff_busy", 128'(busy), 128'd0);
      run_block("bp_second", Pt2, 2'b00, 10, 1'b0, 0, 1'b0);

      // Abort in the middle of round 6.
      in_block = Pt2;
      mode_in  = 2'b10;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!(round == 4'd6 && width_sel == 4'd9) && guard < 400) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("abort_reached", 128'(guard < 400), 128'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_out_valid", 128'(out_valid), 128'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_abort_out_valid", 128'(out_valid), 128'd0);
      chk("post_abort_in_ready", 128'(in_ready), 128'd1);
      run_block("post_abort", Pt1, 2'b00, 10, 1'b0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
